// File: rtl/ip_acc_stage.sv
// ip_acc_stage: accumulates per-chunk partial sums into one dot product per vector.
// Optional IP_ACC_SAT_EN: saturating adds plus a sticky sat_flag output.
`timescale 1ns/1ps

module ip_acc_stage #(
  parameter int bitwidth    = 16,
  parameter int accBitwidth = 32,
  parameter int stage       = 1,
  parameter int cntWidth    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic [bitwidth-1:0]    sum_r,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [accBitwidth-1:0] result,
  output logic [cntWidth-1:0]    chunk_cnt
`ifdef IP_ACC_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                 state_q, state_d;
  logic [stage-1:0]       dl_valid_q, dl_valid_d;
  logic [stage-1:0]       dl_last_q, dl_last_d;
  logic [accBitwidth-1:0] acc_q, acc_d;
  logic [cntWidth-1:0]    cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic                   blocked_q, blocked_d;
  logic                   accept;
  logic                   tap_valid;
  logic                   tap_last;
  logic [accBitwidth-1:0] sum_ext;
  logic [accBitwidth-1:0] add_val;
`ifdef IP_ACC_SAT_EN
  logic                   sat_q, sat_d;
  logic [accBitwidth:0]   wide_sum;
  logic                   add_ovf;
`endif

  assign accept    = in_valid && in_ready;
  assign tap_valid = dl_valid_q[stage-1];
  assign tap_last  = dl_last_q[stage-1];
  assign sum_ext   = accBitwidth'(signed'(sum_r));

  // sum_r has no qualifier, so the issue markers ride a delay line matched to upstream latency
  always_comb begin
    dl_valid_d    = dl_valid_q << 1;
    dl_last_d     = dl_last_q << 1;
    dl_valid_d[0] = accept;
    dl_last_d[0]  = accept && in_last;
  end

`ifdef IP_ACC_SAT_EN
  assign wide_sum = (accBitwidth+1)'(signed'(acc_q)) + (accBitwidth+1)'(signed'(sum_r));
  assign add_ovf  = wide_sum[accBitwidth] != wide_sum[accBitwidth-1];
  always_comb begin
    add_val = wide_sum[accBitwidth-1:0];
    if (add_ovf) begin
      add_val = wide_sum[accBitwidth] ? {1'b1, {(accBitwidth-1){1'b0}}}
                                      : {1'b0, {(accBitwidth-1){1'b1}}};
    end
  end
`else
  assign add_val = acc_q + sum_ext;
`endif

  // Issue stays closed from the last chunk until the held result is taken
  always_comb begin
    blocked_d = blocked_q;
    if (accept && in_last) blocked_d = 1'b1;
    if (out_valid_q && out_ready) blocked_d = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
`ifdef IP_ACC_SAT_EN
    sat_d       = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (tap_valid) begin
          acc_d       = sum_ext;
          cnt_d       = cnt_q + cntWidth'(1);
          state_d     = tap_last ? DONE : ACC;
          out_valid_d = tap_last;
        end
      end
      ACC: begin
        if (tap_valid) begin
          acc_d = add_val;
          cnt_d = cnt_q + cntWidth'(1);
`ifdef IP_ACC_SAT_EN
          sat_d = sat_q || add_ovf;
`endif
          if (tap_last) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
`ifdef IP_ACC_SAT_EN
          sat_d       = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dl_valid_q  <= '0;
      dl_last_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      blocked_q   <= 1'b0;
`ifdef IP_ACC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dl_valid_q  <= dl_valid_d;
      dl_last_q   <= dl_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      blocked_q   <= blocked_d;
`ifdef IP_ACC_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign in_ready  = !blocked_q;
  assign out_valid = out_valid_q;
  assign result    = acc_q;
  assign chunk_cnt = cnt_q;
`ifdef IP_ACC_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_ip_acc_stage.sv
// Testbench for ip_acc_stage: three instances (stage=1/acc32, stage=3/acc32, stage=1/acc16)
// driven by directed vectors, with a scoreboard monitor checking each result handshake.
`timescale 1ns/1ps

module tb_ip_acc_stage;

   typedef struct {
      int          sel;
      logic [31:0] res;
      logic [7:0]  cnt;
      int          lat;
      logic        sat;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst_n;
   logic [2:0]  inValid, inLast, inReady, outValid, outReady;
   logic [15:0] xIn [3];
   logic [15:0] p0, p1a, p1b, p1c, p2;
   logic [31:0] res0, res1;
   logic [15:0] res2;
   logic [7:0]  cnt0, cnt1, cnt2;
`ifdef IP_ACC_SAT_EN
   logic [2:0]  satW;
`endif

   exp_t        sbQ[$];
   int          lastAcc[3];
   int          cyc = 0;
   int          nChecks = 0;
   int          nFails = 0;
   logic [2:0]  prevValid = 3'b000;

   // Free-running clock, 10ns period
   always #5 clock = ~clock;

   // Cycle counter used to measure issue-to-result latency
   always @(posedge clock) cyc <= cyc + 1;

   // Upstream inner-product model: partial sum appears stage cycles after the issue
   always @(posedge clock) begin
      p0  <= xIn[0];
      p1a <= xIn[1];
      p1b <= p1a;
      p1c <= p1b;
      p2  <= xIn[2];
   end

   ip_acc_stage #(.bitwidth(16), .accBitwidth(32), .stage(1), .cntWidth(8)) dut0 (
      .clk(clock), .rst_n(rst_n), .in_valid(inValid[0]), .in_last(inLast[0]),
      .in_ready(inReady[0]), .sum_r(p0), .out_valid(outValid[0]), .out_ready(outReady[0]),
      .result(res0), .chunk_cnt(cnt0)
`ifdef IP_ACC_SAT_EN
      , .sat_flag(satW[0])
`endif
   );

   ip_acc_stage #(.bitwidth(16), .accBitwidth(32), .stage(3), .cntWidth(8)) dut1 (
      .clk(clock), .rst_n(rst_n), .in_valid(inValid[1]), .in_last(inLast[1]),
      .in_ready(inReady[1]), .sum_r(p1c), .out_valid(outValid[1]), .out_ready(outReady[1]),
      .result(res1), .chunk_cnt(cnt1)
`ifdef IP_ACC_SAT_EN
      , .sat_flag(satW[1])
`endif
   );

   ip_acc_stage #(.bitwidth(16), .accBitwidth(16), .stage(1), .cntWidth(8)) dut2 (
      .clk(clock), .rst_n(rst_n), .in_valid(inValid[2]), .in_last(inLast[2]),
      .in_ready(inReady[2]), .sum_r(p2), .out_valid(outValid[2]), .out_ready(outReady[2]),
      .result(res2), .chunk_cnt(cnt2)
`ifdef IP_ACC_SAT_EN
      , .sat_flag(satW[2])
`endif
   );

   function automatic logic [31:0] resOf(input int s);
      case (s)
         0:       return res0;
         1:       return res1;
         default: return {16'h0000, res2};
      endcase
   endfunction

   function automatic logic [31:0] cntOf(input int s);
      case (s)
         0:       return {24'h0, cnt0};
         1:       return {24'h0, cnt1};
         default: return {24'h0, cnt2};
      endcase
   endfunction

   // One comparison: counts it, and reports actual vs required on a miss
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act !== req) begin
         nFails++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic pushExp(input int s, input logic [31:0] r, input logic [7:0] c,
                          input int lat, input logic sat);
      exp_t e;
      e.sel = s;
      e.res = r;
      e.cnt = c;
      e.lat = lat;
      e.sat = sat;
      sbQ.push_back(e);
   endtask

   // Issue one chunk to instance s, holding it until in_ready lets it through
   task automatic applyStimulus(input int s, input logic [15:0] x, input logic last);
      int waited = 0;
      xIn[s]     = x;
      inLast[s]  = last;
      inValid[s] = 1'b1;
      @(negedge clock);
      while (!inReady[s] && waited < 50) begin
         waited++;
         @(negedge clock);
      end
      if (!inReady[s]) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL issue_timeout: actual in_ready=0 required=1 (dut%0d)", s);
      end else if (last) begin
         lastAcc[s] = cyc;
      end
      @(posedge clock);
      #1;
      inValid[s] = 1'b0;
      inLast[s]  = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (sbQ.size() != 0 && n < 60) begin
         n++;
         @(negedge clock);
      end
      if (sbQ.size() != 0) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL drain_timeout: actual pending=%0d required=0", sbQ.size());
      end
      repeat (2) @(posedge clock);
      #1;
   endtask

   // Scoreboard monitor: checks latency on out_valid rise and values on each handshake
   always @(negedge clock) begin
      for (int s = 0; s < 3; s++) begin
         if (outValid[s] && !prevValid[s] && sbQ.size() != 0 && sbQ[0].sel == s)
            checkOutput("latency", cyc - lastAcc[s], sbQ[0].lat);
         if (outValid[s] && outReady[s]) begin
            if (sbQ.size() == 0 || sbQ[0].sel != s) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL unexpected_result: actual dut%0d result=%0h required no result",
                        s, resOf(s));
            end else begin
               checkOutput("result", resOf(s), sbQ[0].res);
               checkOutput("chunk_cnt", cntOf(s), {24'h0, sbQ[0].cnt});
`ifdef IP_ACC_SAT_EN
               checkOutput("sat_flag", {31'h0, satW[s]}, {31'h0, sbQ[0].sat});
`endif
               sbQ.delete(0);
            end
         end
      end
      prevValid <= outValid;
   end

   initial begin
      int n;
      rst_n    = 1'b0;
      inValid  = 3'b000;
      inLast   = 3'b000;
      outReady = 3'b111;
      for (int i = 0; i < 3; i++) begin
         xIn[i]     = 16'h0000;
         lastAcc[i] = 0;
      end
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_out_valid", {29'h0, outValid}, 32'h0);
      checkOutput("reset_result", res0, 32'h0);
      checkOutput("reset_chunk_cnt", cntOf(0), 32'h0);
      checkOutput("reset_in_ready", {29'h0, inReady}, 32'h7);
      rst_n = 1'b1;
      @(posedge clock);
      #1;

      // Three chunks 5, -3, 10
      pushExp(0, 32'd12, 8'd3, 2, 1'b0);
      applyStimulus(0, 16'd5, 1'b0);
      applyStimulus(0, 16'hFFFD, 1'b0);
      applyStimulus(0, 16'd10, 1'b1);
      waitDrain();

      // Single chunk -7 sign-extends to 32 bits
      pushExp(0, 32'hFFFFFFF9, 8'd1, 2, 1'b0);
      applyStimulus(0, 16'hFFF9, 1'b1);
      waitDrain();

      // Back-to-back with result held for 4 cycles
      outReady[0] = 1'b0;
      pushExp(0, 32'd100, 8'd2, 2, 1'b0);
      pushExp(0, 32'd1, 8'd1, 2, 1'b0);
      applyStimulus(0, 16'd60, 1'b0);
      applyStimulus(0, 16'd40, 1'b1);
      fork
         applyStimulus(0, 16'd1, 1'b1);
         begin
            n = 0;
            @(negedge clock);
            while (!outValid[0] && n < 20) begin
               n++;
               @(negedge clock);
            end
            repeat (4) begin
               @(negedge clock);
               checkOutput("hold_in_ready", {31'h0, inReady[0]}, 32'h0);
               checkOutput("hold_out_valid", {31'h0, outValid[0]}, 32'h1);
               checkOutput("hold_result", res0, 32'd100);
            end
            @(posedge clock);
            #1;
            outReady[0] = 1'b1;
         end
      join
      waitDrain();

      // Reset mid-vector after 2 of 4 chunks discards the partial sum
      applyStimulus(0, 16'd9, 1'b0);
      applyStimulus(0, 16'd9, 1'b0);
      @(posedge clock);
      @(negedge clock);
      checkOutput("pre_reset_cnt", cntOf(0), 32'd2);
      checkOutput("pre_reset_result", res0, 32'd18);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_result", res0, 32'h0);
      checkOutput("async_reset_cnt", cntOf(0), 32'h0);
      checkOutput("async_reset_valid", {31'h0, outValid[0]}, 32'h0);
      checkOutput("async_reset_in_ready", {31'h0, inReady[0]}, 32'h1);
      @(posedge clock);
      #2;
      rst_n = 1'b1;
      @(posedge clock);
      #1;
      pushExp(0, 32'd8, 8'd2, 2, 1'b0);
      applyStimulus(0, 16'd4, 1'b0);
      applyStimulus(0, 16'd4, 1'b1);
      waitDrain();

      // stage=3 instance, consecutive issues
      pushExp(1, 32'd6, 8'd3, 4, 1'b0);
      applyStimulus(1, 16'd1, 1'b0);
      applyStimulus(1, 16'd2, 1'b0);
      applyStimulus(1, 16'd3, 1'b1);
      waitDrain();

      // 16-bit accumulator overflow: saturates or wraps depending on build
`ifdef IP_ACC_SAT_EN
      pushExp(2, 32'h00007FFF, 8'd2, 2, 1'b1);
`else
      pushExp(2, 32'h00008000, 8'd2, 2, 1'b0);
`endif
      applyStimulus(2, 16'h7FFF, 1'b0);
      applyStimulus(2, 16'h0001, 1'b1);
      waitDrain();

      checkOutput("queue_empty", sbQ.size(), 32'h0);
      checkOutput("idle_out_valid", {29'h0, outValid}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
